// File: rtl/conv_syndrome_checker.sv
// Receive-side syndrome checker for the rate-1/2 systematic convolutional code.
// Realigns incoming {info, parity} pairs, re-encodes the info stream with the
// 36-tap parity mask through a pipelined XOR tree, and emits one syndrome bit
// per pair. A flush/search/lock state machine picks the pair alignment and
// reports the syndrome count of each measurement window.
module conv_syndrome_checker #(
  parameter int WIN        = 256,
  parameter int THR_LOCK   = 16,
  parameter int THR_UNLOCK = 64,
  parameter int FLUSH_LEN  = 48
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       i_vld,
  input  logic [1:0]                 i_word,
  output logic                       o_vld,
  output logic                       o_sym,
  output logic                       o_syn,
  output logic                       o_phase,
  output logic                       o_lock,
  output logic                       o_win_stb,
  output logic [$clog2(WIN+1)-1:0]   o_err_cnt
);

  localparam int EW   = $clog2(WIN + 1);
  localparam int CMAX = (WIN > FLUSH_LEN) ? WIN : FLUSH_LEN;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [35:0] MASK = 36'hD354E3267;

  typedef enum logic [1:0] {ST_FLUSH, ST_SEARCH, ST_LOCKED} state_t;

  // Front end: alignment and info history
  logic        held_lo_reg;
  logic        phase_reg;
  logic        rx_info;
  logic        rx_par;
  logic [35:0] sr_reg;

  // Pipeline: valid/info/parity delay lines alongside the XOR tree
  logic [5:0]  vld_pipe;
  logic [5:0]  info_pipe;
  logic [5:0]  par_pipe;
  logic [63:0] prod;
  logic [31:0] lvl1_reg, lvl1_next;
  logic [15:0] lvl2_reg, lvl2_next;
  logic [7:0]  lvl3_reg, lvl3_next;
  logic [3:0]  lvl4_reg, lvl4_next;
  logic [1:0]  lvl5_reg, lvl5_next;

  // FSM
  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [EW-1:0]   err_reg, err_next;
  logic [EW-1:0]   err_inc;
  logic [EW-1:0]   err_out_reg, err_out_next;
  logic            stb_reg, stb_next;
  logic            phase_next;

  // In slipped alignment the pair straddles two received words: the previous
  // word's low bit is the info bit and the current word's high bit is parity.
  assign rx_info = phase_reg ? held_lo_reg : i_word[1];
  assign rx_par  = phase_reg ? i_word[1]   : i_word[0];

  // Capture the low bit of each word and shift the realigned info bit in.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      held_lo_reg <= 1'b0;
      sr_reg      <= '0;
    end else if (i_vld) begin
      held_lo_reg <= i_word[0];
      sr_reg      <= {sr_reg[34:0], rx_info};
    end
  end

  // Mask-AND of the info history, zero-padded to a power-of-two tree.
  assign prod = {28'd0, sr_reg & MASK};

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_lvl1
      assign lvl1_next[gi] = prod[2*gi] ^ prod[2*gi+1];
    end
    for (gi = 0; gi < 16; gi++) begin : g_lvl2
      assign lvl2_next[gi] = lvl1_reg[2*gi] ^ lvl1_reg[2*gi+1];
    end
    for (gi = 0; gi < 8; gi++) begin : g_lvl3
      assign lvl3_next[gi] = lvl2_reg[2*gi] ^ lvl2_reg[2*gi+1];
    end
    for (gi = 0; gi < 4; gi++) begin : g_lvl4
      assign lvl4_next[gi] = lvl3_reg[2*gi] ^ lvl3_reg[2*gi+1];
    end
    for (gi = 0; gi < 2; gi++) begin : g_lvl5
      assign lvl5_next[gi] = lvl4_reg[2*gi] ^ lvl4_reg[2*gi+1];
    end
  endgenerate

  // Free-running XOR tree and matching delay lines; final stage folds in
  // the received parity so the output is the syndrome directly.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vld_pipe  <= '0;
      info_pipe <= '0;
      par_pipe  <= '0;
      lvl1_reg  <= '0;
      lvl2_reg  <= '0;
      lvl3_reg  <= '0;
      lvl4_reg  <= '0;
      lvl5_reg  <= '0;
      o_vld     <= 1'b0;
      o_sym     <= 1'b0;
      o_syn     <= 1'b0;
    end else begin
      vld_pipe  <= {vld_pipe[4:0], i_vld};
      info_pipe <= {info_pipe[4:0], rx_info};
      par_pipe  <= {par_pipe[4:0], rx_par};
      lvl1_reg  <= lvl1_next;
      lvl2_reg  <= lvl2_next;
      lvl3_reg  <= lvl3_next;
      lvl4_reg  <= lvl4_next;
      lvl5_reg  <= lvl5_next;
      o_vld     <= vld_pipe[5];
      o_sym     <= vld_pipe[5] & info_pipe[5];
      o_syn     <= vld_pipe[5] & (lvl5_reg[1] ^ lvl5_reg[0] ^ par_pipe[5]);
    end
  end

  // Window error count including the syndrome presented this cycle, saturating.
  always_comb begin
    err_inc = err_reg;
    if (o_syn && (err_reg != EW'(WIN))) begin
      err_inc = err_reg + 1'b1;
    end
  end

  // Next-state logic: counters advance only on valid outputs and clear on entry.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    err_next     = err_reg;
    err_out_next = err_out_reg;
    stb_next     = 1'b0;
    phase_next   = phase_reg;
    case (state_reg)
      ST_FLUSH: begin
        if (o_vld) begin
          if (cnt_reg == CW'(FLUSH_LEN - 1)) begin
            state_next = ST_SEARCH;
            cnt_next   = '0;
            err_next   = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      ST_SEARCH: begin
        if (o_vld) begin
          if (cnt_reg == CW'(WIN - 1)) begin
            stb_next     = 1'b1;
            err_out_next = err_inc;
            cnt_next     = '0;
            err_next     = '0;
            if (int'(err_inc) <= THR_LOCK) begin
              state_next = ST_LOCKED;
            end else begin
              state_next = ST_FLUSH;
              phase_next = ~phase_reg;
            end
          end else begin
            cnt_next = cnt_reg + 1'b1;
            err_next = err_inc;
          end
        end
      end
      ST_LOCKED: begin
        if (o_vld) begin
          if (cnt_reg == CW'(WIN - 1)) begin
            stb_next     = 1'b1;
            err_out_next = err_inc;
            cnt_next     = '0;
            err_next     = '0;
            if (int'(err_inc) > THR_UNLOCK) begin
              state_next = ST_SEARCH;
            end
          end else begin
            cnt_next = cnt_reg + 1'b1;
            err_next = err_inc;
          end
        end
      end
      default: begin
        state_next = ST_FLUSH;
        cnt_next   = '0;
        err_next   = '0;
      end
    endcase
  end

  // FSM state, counters, alignment phase and window report registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg   <= ST_FLUSH;
      cnt_reg     <= '0;
      err_reg     <= '0;
      err_out_reg <= '0;
      stb_reg     <= 1'b0;
      phase_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      err_reg     <= err_next;
      err_out_reg <= err_out_next;
      stb_reg     <= stb_next;
      phase_reg   <= phase_next;
    end
  end

  assign o_phase   = phase_reg;
  assign o_lock    = (state_reg == ST_LOCKED);
  assign o_win_stb = stb_reg;
  assign o_err_cnt = err_out_reg;

endmodule

// File: tb/tb_conv_syndrome_checker.sv
// Scoreboard bench for conv_syndrome_checker: the driver pushes the expected
// per-pair response, a monitor pops on every o_vld and logs window reports.
module tb_conv_syndrome_checker;

  localparam logic [35:0] M = 36'hD354E3267;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       i_vld = 1'b0;
  logic [1:0] i_word = 2'b00;
  logic       o_vld, o_sym, o_syn, o_phase, o_lock, o_win_stb;
  logic [8:0] o_err_cnt;

  conv_syndrome_checker dut (
    .clk(clk), .reset_n(reset_n), .i_vld(i_vld), .i_word(i_word),
    .o_vld(o_vld), .o_sym(o_sym), .o_syn(o_syn), .o_phase(o_phase),
    .o_lock(o_lock), .o_win_stb(o_win_stb), .o_err_cnt(o_err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { bit chk; bit sym; bit syn; int t; } exp_t;
  typedef struct { int at; int err; bit lock; bit phase; } win_t;

  exp_t        sbq[$];
  win_t        wq[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          out_cnt = 0;
  int          pidx = 0;
  bit          syn_hist[0:4095];
  logic [35:0] tx_sr = '0;
  logic [35:0] rx_sr = '0;
  bit          u_arr[0:1023];
  bit          p_arr[0:1023];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d at cycle %0d", nm, act, exp_v, cyc);
    end else begin
      $display("ok   %s = %0d", nm, act);
    end
  endtask

  function automatic bit tx_step(input bit u);
    tx_sr = {tx_sr[34:0], u};
    return ^(tx_sr & M);
  endfunction

  function automatic bit rx_step(input bit info, input bit par);
    rx_sr = {rx_sr[34:0], info};
    return par ^ (^(rx_sr & M));
  endfunction

  task automatic drive_pair(input bit info, input bit par, input bit c,
                            input bit esym, input bit esyn);
    exp_t e;
    @(posedge clk); #1;
    i_vld  = 1'b1;
    i_word = {info, par};
    e = '{c, esym, esyn, cyc};
    sbq.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      i_vld  = 1'b0;
      i_word = 2'b00;
    end
  endtask

  // Encode one random info bit, optionally corrupt the channel, predict syndrome.
  task automatic send_enc(input bit flip_info, input bit flip_par);
    bit u, p, ru, rp, s;
    u  = 1'($urandom_range(0, 1));
    p  = tx_step(u);
    ru = u ^ flip_info;
    rp = p ^ flip_par;
    s  = rx_step(ru, rp);
    syn_hist[pidx] = s;
    pidx++;
    drive_pair(ru, rp, 1'b1, ru, s);
  endtask

  task automatic do_reset(input int n);
    chk("stale_window_reports", wq.size(), 0);
    @(posedge clk); #1;
    reset_n = 1'b0;
    i_vld   = 1'b0;
    i_word  = 2'b00;
    sbq.delete();
    repeat (n) @(posedge clk);
    #1;
    chk("reset_outputs", int'({o_vld, o_sym, o_syn, o_phase, o_lock, o_win_stb, o_err_cnt}), 0);
    reset_n = 1'b1;
    tx_sr = '0;
    rx_sr = '0;
    pidx  = 0;
  endtask

  task automatic expect_win(input string nm, input int at, input int err,
                            input bit lock, input bit phase);
    win_t w;
    int   n;
    n = 0;
    while (wq.size() == 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (wq.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s_timeout no window strobe within 3000 cycles, required one", nm);
    end else begin
      w = wq.pop_front();
      chk({nm, "_at"}, w.at, at);
      chk({nm, "_err"}, w.err, err);
      chk({nm, "_lock"}, int'(w.lock), int'(lock));
      chk({nm, "_phase"}, int'(w.phase), int'(phase));
    end
  endtask

  function automatic int hist_sum(input int lo, input int hi);
    int s;
    s = 0;
    for (int i = lo; i <= hi; i++) s += int'(syn_hist[i]);
    return s;
  endfunction

  // Monitor: log window reports, then check each valid output against the queue.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        out_cnt = 0;
      end else begin
        if (o_win_stb) wq.push_back('{out_cnt, int'(o_err_cnt), o_lock, o_phase});
        if (o_vld) begin
          if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_empty output %0d with no pending pair", out_cnt);
          end else begin
            e = sbq.pop_front();
            total++;
            if (cyc - e.t != 7 || (e.chk && (o_sym != e.sym || o_syn != e.syn))) begin
              bad++;
              $display("FAIL out%0d latency=%0d sym=%0b syn=%0b, required latency=7 sym=%0b syn=%0b",
                       out_cnt, cyc - e.t, o_sym, o_syn, e.sym, e.syn);
            end
          end
          out_cnt++;
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int e_b, e_c, e_d;
    do_reset(3);

    // Clean stream; info flip at 420 and parity flip at 600 while locked.
    for (int k = 0; k < 816; k++) send_enc(k == 420, k == 600);
    idle(20);
    expect_win("clean_lock", 304, 0, 1'b1, 1'b0);
    expect_win("info_flip", 560, 19, 1'b1, 1'b0);
    expect_win("par_flip", 816, 1, 1'b1, 1'b0);

    // 30 % random bit errors for one window: lock must drop, phase kept.
    for (int k = 0; k < 256; k++)
      send_enc($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 3);
    idle(20);
    e_b = hist_sum(816, 1071);
    total++;
    if (e_b <= 64) begin
      bad++;
      $display("FAIL noise_level model count=%0d, required > 64", e_b);
    end
    expect_win("noisy", 1072, e_b, 1'b0, 1'b0);
    // Back to SEARCH (no flush): next window covers outputs 1072..1327.
    for (int k = 0; k < 260; k++) send_enc(1'b0, 1'b0);
    idle(20);
    e_c = hist_sum(1072, 1327);
    expect_win("research", 1328, e_c, e_c <= 16, e_c > 16);

    // Gapped input, reset mid-window, then relock from scratch.
    do_reset(2);
    for (int k = 0; k < 150; k++) begin
      send_enc(1'b0, 1'b0);
      if ($urandom_range(0, 1) == 1) idle(1 + $urandom_range(0, 1));
    end
    do_reset(3);
    for (int k = 0; k < 320; k++) begin
      send_enc(1'b0, 1'b0);
      if ($urandom_range(0, 1) == 1) idle(1 + $urandom_range(0, 1));
    end
    idle(20);
    expect_win("gap_relock", 304, 0, 1'b1, 1'b0);

    // Stream slipped by one bit: search fails, phase flips, then lock.
    do_reset(3);
    for (int k = 0; k < 700; k++) begin
      u_arr[k] = 1'($urandom_range(0, 1));
      p_arr[k] = tx_step(u_arr[k]);
    end
    e_d = 0;
    for (int k = 0; k < 700; k++) begin
      bit w1, w0, s;
      w1 = (k == 0) ? 1'b0 : p_arr[k-1];
      w0 = u_arr[k];
      if (k < 304) begin
        s = rx_step(w1, w0);
        if (k >= 48) e_d += int'(s);
      end
      drive_pair(w1, w0, k >= 400, (k == 0) ? 1'b0 : u_arr[k-1], 1'b0);
    end
    idle(20);
    expect_win("slip_search", 304, e_d, 1'b0, 1'b1);
    expect_win("slip_lock", 608, 0, 1'b1, 1'b1);
    chk("slip_final_phase", int'(o_phase), 1);
    chk("slip_pending", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv_syndrome_checker.md
# conv_syndrome_checker

Receive-side companion of the rate-1/2 systematic convolutional encoder: takes hard-decision {info, parity} pairs from the demodulator, re-encodes the info bits with the same 36-tap parity mask and emits per-pair syndromes alongside the recovered info bits. A flush/search/lock state machine resolves the one-bit pair-boundary ambiguity and reports channel quality. Sits ahead of the Fano decoder as its alignment and error-rate front end.

## Interface
- WIN, 256: valid output pairs per measurement window (≥ 64)
- THR_LOCK, 16: window syndrome count ≤ this in SEARCH → lock
- THR_UNLOCK, 64: window syndrome count > this in LOCKED → lose lock
- FLUSH_LEN, 48: output pairs ignored after reset/phase change (≥ 43)
- clk  in  1  clock
- reset_n  in  1  reset, synchronous, active-low
- i_vld  in  1  input pair valid (gaps allowed)
- i_word  in  2  [1] = info bit, [0] = parity bit
- o_vld  out  1  output pair valid
- o_sym  out  1  recovered info bit
- o_syn  out  1  syndrome bit (1 = parity mismatch)
- o_phase  out  1  current pair alignment (0 = as received, 1 = slipped one bit)
- o_lock  out  1  locked indicator
- o_win_stb  out  1  one-cycle pulse at each window end
- o_err_cnt  out  clog2(WIN+1)  syndrome count of last completed window

## Operation
- Code: mask M = 36'hD354E3267 (weight 19), M[0] = tap on current bit. Parity p_k = XOR over j=0..35 of M[j]·u_{k-j}. Syndrome s_k = r_p_k XOR p_k computed from received u.
- Realignment: held_lo ← i_word[0] on every i_vld. phase 0: pair = i_word; phase 1: pair = {held_lo, i_word[1]}.
- Info shift register (36 b) shifts in realigned info bit at bit 0 on each i_vld; not cleared on phase change.
- Parity: mask-AND then 6-stage registered XOR tree (64→32→16→8→4→2→1), free-running every clock; received parity and info bit carried in matching delay lines.
- FSM (counts on o_vld only, window counter and error counter clear on every state entry):
  - FLUSH: count FLUSH_LEN valid outputs, ignore syndromes → SEARCH.
  - SEARCH: accumulate WIN syndromes; at window end pulse o_win_stb, latch o_err_cnt; count ≤ THR_LOCK → LOCKED; else toggle phase → FLUSH.
  - LOCKED: o_lock = 1; at window end pulse, latch; count > THR_UNLOCK → SEARCH (phase kept); else stay, restart window.
- Error counter saturates at WIN (cannot overflow by construction).
- Window-end pair's syndrome is included in that window's count.

## Timing
- Reset: all outputs 0, FSM = FLUSH, phase 0, shift register/delay lines/counters 0. Reset mid-operation discards in-flight pairs; o_vld stays 0 until 7 cycles after next i_vld.
- Latency: pair accepted at cycle t (i_vld = 1) → o_vld/o_sym/o_syn at cycle t+7, independent of gaps; back-to-back input gives back-to-back output.
- o_sym lags: o_sym at output n = realigned info bit of input pair n.
- Phase toggle takes effect on the first i_vld after the cycle the SEARCH window ends; in-flight old-phase pairs (≤ 7) fall inside the flush.
- o_win_stb, o_err_cnt update and state change occur on the same edge, with the cycle after the window's last o_vld; o_lock changes on that edge.
- Minimum lock acquisition from reset on clean data: FLUSH_LEN + WIN output pairs.

## Test plan
- Clean encoded random stream, phase 0, continuous i_vld, 400 pairs → o_syn = 0 after first 36 outputs, o_sym = input info delayed 7 cycles, o_err_cnt = 0, o_lock rises after output 304.
- Same stream, one info bit flipped at pair 100 (locked) → exactly 19 syndrome ones at outputs 100+j for every j with M[j] = 1; o_err_cnt = 19 for that window, lock held.
- One parity bit flipped at pair 150 → single o_syn = 1 at output 150; window count 1.
- Stream slipped by one bit → first SEARCH window count ≈ WIN/2 > 16, o_phase → 1, FLUSH, then lock after next window; o_sym matches original info.
- Locked, then 30 % random bit errors for 2 windows → o_err_cnt > 64, o_lock falls, state SEARCH, o_phase unchanged.
- Random i_vld gaps (50 % duty) plus reset_n low 3 cycles mid-window → 7-cycle latency preserved per pair; after reset all outputs 0, FLUSH restarts, relock after FLUSH_LEN + WIN pairs.
